rf_read_stage: RTL and testbench

- Decode-side register-read stage placed directly upstream of the 2-read/1-write synchronous register-file RAM in the RV32I pipeline.
- Accepts source-register indices from decode and drives the RAM read ports.
- Passes writeback traffic through to the RAM write port.
- Realigns the 1-cycle RAM read data with a valid/ready handshake to execute. Handles x0, same-cycle write/read collisions and write-snooping while execute is stalled.

---
 rtl/rf_read_stage.sv | 129 ++++++++++++
 tb/tb_rf_read_stage.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_read_stage.sv
// Register-read stage between decode and the 2R1W register-file RAM; realigns read data to execute.
// Optional macro RF_READ_BYPASS_EN: capture same-cycle writeback data instead of stalling decode.
module rf_read_stage #(
    parameter int width_p       = 32,
    parameter int els_p         = 32,
    parameter int tag_width_p   = 32,
    localparam int addr_width_lp = $clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     id_v_i,
    output logic                     id_ready_o,
    input  logic [addr_width_lp-1:0] id_rs1_i,
    input  logic [addr_width_lp-1:0] id_rs2_i,
    input  logic [tag_width_p-1:0]   id_tag_i,
    input  logic                     wb_v_i,
    input  logic [addr_width_lp-1:0] wb_rd_i,
    input  logic [width_p-1:0]       wb_data_i,
    output logic                     rf_w_v_o,
    output logic [addr_width_lp-1:0] rf_w_addr_o,
    output logic [width_p-1:0]       rf_w_data_o,
    output logic                     rf_r0_v_o,
    output logic [addr_width_lp-1:0] rf_r0_addr_o,
    input  logic [width_p-1:0]       rf_r0_data_i,
    output logic                     rf_r1_v_o,
    output logic [addr_width_lp-1:0] rf_r1_addr_o,
    input  logic [width_p-1:0]       rf_r1_data_i,
    output logic                     ex_v_o,
    input  logic                     ex_ready_i,
    output logic [width_p-1:0]       ex_rs1_data_o,
    output logic [width_p-1:0]       ex_rs2_data_o,
    output logic [tag_width_p-1:0]   ex_tag_o
);

    typedef enum logic [1:0] { ST_EMPTY, ST_FRESH, ST_HELD } state_e;
    typedef enum logic [1:0] { SRC_ZERO, SRC_RAM, SRC_COLL } src_e;

    state_e                          state_q;
    src_e                            src_q [2];
    logic [1:0][addr_width_lp-1:0]   rs_in;
    logic [1:0][addr_width_lp-1:0]   rs_q;
    logic [1:0][width_p-1:0]         rdata;
    logic [1:0][width_p-1:0]         hold_q;
    logic [1:0][width_p-1:0]         disp;
    logic [tag_width_p-1:0]          tag_q;
    logic [1:0]                      rs_nz;
    logic [1:0]                      coll;
    logic [1:0]                      snoop;
    logic                            acc;

    // Operand 0 is rs1 / RAM read port 0, operand 1 is rs2 / RAM read port 1.
    assign rs_in = {id_rs2_i, id_rs1_i};
    assign rdata = {rf_r1_data_i, rf_r0_data_i};

    assign rf_w_v_o    = wb_v_i & (wb_rd_i != '0);
    assign rf_w_addr_o = wb_rd_i;
    assign rf_w_data_o = wb_data_i;

    assign ex_v_o        = (state_q != ST_EMPTY);
    assign ex_tag_o      = tag_q;
    assign ex_rs1_data_o = disp[0];
    assign ex_rs2_data_o = disp[1];

    always_comb begin
        for (int n = 0; n < 2; n++) begin
            rs_nz[n] = (rs_in[n] != '0);
            coll[n]  = rf_w_v_o & (wb_rd_i == rs_in[n]);
            snoop[n] = ex_v_o & ~ex_ready_i & rf_w_v_o & (wb_rd_i == rs_q[n]);
            disp[n]  = '0;
            if (state_q == ST_HELD) begin
                disp[n] = hold_q[n];
            end else if (state_q == ST_FRESH) begin
                case (src_q[n])
                    SRC_RAM:  disp[n] = rdata[n];
                    SRC_COLL: disp[n] = hold_q[n];
                    default:  disp[n] = '0;
                endcase
            end
        end
    end

`ifdef RF_READ_BYPASS_EN
    assign id_ready_o = ~ex_v_o | ex_ready_i;
`else
    // Without the bypass a colliding instruction waits one cycle and reads the freshly written RAM.
    assign id_ready_o = (~ex_v_o | ex_ready_i) & ~(id_v_i & (|coll));
`endif

    assign acc = id_v_i & id_ready_o;

    // A colliding operand never reads the RAM, so read and write never share an address.
    assign rf_r0_v_o    = acc & rs_nz[0] & ~coll[0];
    assign rf_r0_addr_o = id_rs1_i;
    assign rf_r1_v_o    = acc & rs_nz[1] & ~coll[1];
    assign rf_r1_addr_o = id_rs2_i;

    // On a stall the displayed operands freeze into the hold registers, merging any write seen this cycle.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_EMPTY;
            tag_q   <= '0;
            rs_q    <= '0;
            hold_q  <= '0;
            for (int n = 0; n < 2; n++) src_q[n] <= SRC_ZERO;
        end else if (acc) begin
            state_q <= ST_FRESH;
            tag_q   <= id_tag_i;
            rs_q    <= rs_in;
            for (int n = 0; n < 2; n++) begin
                if (!rs_nz[n]) begin
                    src_q[n] <= SRC_ZERO;
`ifdef RF_READ_BYPASS_EN
                end else if (coll[n]) begin
                    src_q[n]  <= SRC_COLL;
                    hold_q[n] <= wb_data_i;
`endif
                end else begin
                    src_q[n] <= SRC_RAM;
                end
            end
        end else if (ex_v_o && ex_ready_i) begin
            state_q <= ST_EMPTY;
        end else if (ex_v_o) begin
            state_q <= ST_HELD;
            for (int n = 0; n < 2; n++) hold_q[n] <= snoop[n] ? wb_data_i : disp[n];
        end
    end

endmodule

// File: tb/tb_rf_read_stage.sv
// Self-checking bench for rf_read_stage: a RAM model plus an architectural register-state reference.
// Honours RF_READ_BYPASS_EN the same way the design does.
module tb_rf_read_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_v, id_ready;
    logic [4:0]  id_rs1, id_rs2;
    logic [31:0] id_tag;
    logic        wb_v;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        rf_w_v, rf_r0_v, rf_r1_v;
    logic [4:0]  rf_w_addr, rf_r0_addr, rf_r1_addr;
    logic [31:0] rf_w_data, rf_r0_data, rf_r1_data;
    logic        ex_v, ex_ready;
    logic [31:0] ex_rs1_data, ex_rs2_data, ex_tag;

    logic [31:0] mem  [32];
    logic [31:0] arch [32];
    logic        exp_valid;
    int          exp_rs1, exp_rs2;
    logic [31:0] exp_tag;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    rf_read_stage dut (
        .clk_i(clk), .reset_i(reset),
        .id_v_i(id_v), .id_ready_o(id_ready), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_tag_i(id_tag),
        .wb_v_i(wb_v), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
        .rf_w_v_o(rf_w_v), .rf_w_addr_o(rf_w_addr), .rf_w_data_o(rf_w_data),
        .rf_r0_v_o(rf_r0_v), .rf_r0_addr_o(rf_r0_addr), .rf_r0_data_i(rf_r0_data),
        .rf_r1_v_o(rf_r1_v), .rf_r1_addr_o(rf_r1_addr), .rf_r1_data_i(rf_r1_data),
        .ex_v_o(ex_v), .ex_ready_i(ex_ready),
        .ex_rs1_data_o(ex_rs1_data), .ex_rs2_data_o(ex_rs2_data), .ex_tag_o(ex_tag)
    );

    // Synchronous 2R1W RAM; unread ports return garbage so zero/bypass handling is exercised.
    always @(posedge clk) begin
        if (rf_w_v) mem[rf_w_addr] <= rf_w_data;
        rf_r0_data <= rf_r0_v ? mem[rf_r0_addr] : $urandom;
        rf_r1_data <= rf_r1_v ? mem[rf_r1_addr] : $urandom;
    end

    function automatic logic model_wv();
        return wb_v && (wb_rd != 5'd0);
    endfunction

    function automatic logic model_ready();
        logic r;
        r = !exp_valid || ex_ready;
`ifndef RF_READ_BYPASS_EN
        if (id_v && model_wv() && (wb_rd == id_rs1 || wb_rd == id_rs2)) r = 1'b0;
`endif
        return r;
    endfunction

    // An operand shows the architectural value including every write before the current cycle.
    function automatic logic [31:0] model_opnd(input int rs);
        return (rs == 0) ? 32'd0 : arch[rs];
    endfunction

    task automatic preload(input int r, input int d);
        mem[r]  = d;
        arch[r] = d;
    endtask

    task automatic drive(input int v, input int r1, input int r2, input int tg,
                         input int wv, input int rd, input int wd, input int exr);
        @(negedge clk);
        id_v = 1'(v); id_rs1 = 5'(r1); id_rs2 = 5'(r2); id_tag = tg;
        wb_v = 1'(wv); wb_rd = 5'(rd); wb_data = wd; ex_ready = 1'(exr);
        #1;
    endtask

    task automatic step();
        logic acc;
        acc = id_v && model_ready();
        @(posedge clk);
        if (model_wv()) arch[wb_rd] = wb_data;
        if (acc) begin
            exp_valid = 1'b1; exp_rs1 = int'(id_rs1); exp_rs2 = int'(id_rs2); exp_tag = id_tag;
        end else if (exp_valid && ex_ready) begin
            exp_valid = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; id_v = 0; id_rs1 = 0; id_rs2 = 0; id_tag = 0;
        wb_v = 0; wb_rd = 0; wb_data = 0; ex_ready = 0; exp_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ex_v !== 1'b0) begin failures++; $display("[TB] FAIL reset_ex_v got=%0h want=0", ex_v); end
        checks++; if (id_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_id_ready got=%0h want=1", id_ready); end
        checks++; if ({rf_w_v, rf_r0_v, rf_r1_v} !== 3'b000) begin failures++; $display("[TB] FAIL reset_rf_enables got=%0b want=000", {rf_w_v, rf_r0_v, rf_r1_v}); end
        checks++; if (ex_rs1_data !== 32'd0 || ex_rs2_data !== 32'd0) begin failures++; $display("[TB] FAIL reset_operands got=%0h/%0h want=0/0", ex_rs1_data, ex_rs2_data); end
        checks++; if (ex_tag !== 32'd0) begin failures++; $display("[TB] FAIL reset_tag got=%0h want=0", ex_tag); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic_read();
        preload(5, 32'h11);
        preload(6, 32'h22);
        drive(1, 5, 6, 32'hC0DE0001, 0, 0, 0, 1);
        checks++; if (id_ready !== 1'b1) begin failures++; $display("[TB] FAIL basic_id_ready got=%0h want=1", id_ready); end
        checks++; if ({rf_r0_v, rf_r1_v} !== 2'b11) begin failures++; $display("[TB] FAIL basic_read_en got=%0b want=11", {rf_r0_v, rf_r1_v}); end
        checks++; if (rf_r0_addr !== 5'd5 || rf_r1_addr !== 5'd6) begin failures++; $display("[TB] FAIL basic_read_addr got=%0d/%0d want=5/6", rf_r0_addr, rf_r1_addr); end
        step();
        checks++; if (ex_v !== 1'b1) begin failures++; $display("[TB] FAIL basic_ex_v got=%0h want=1", ex_v); end
        checks++; if (ex_rs1_data !== 32'h11 || ex_rs2_data !== 32'h22) begin failures++; $display("[TB] FAIL basic_operands got=%0h/%0h want=11/22", ex_rs1_data, ex_rs2_data); end
        checks++; if (ex_tag !== 32'hC0DE0001) begin failures++; $display("[TB] FAIL basic_tag got=%0h want=c0de0001", ex_tag); end
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        step();
        checks++; if (ex_v !== 1'b0) begin failures++; $display("[TB] FAIL basic_drain got=%0h want=0", ex_v); end
    endtask

    task automatic test_zero_reg();
        drive(1, 0, 0, 32'h0000_0002, 1, 0, 32'hFF, 1);
        checks++; if (rf_w_v !== 1'b0) begin failures++; $display("[TB] FAIL x0_write_dropped got=%0h want=0", rf_w_v); end
        checks++; if ({rf_r0_v, rf_r1_v} !== 2'b00) begin failures++; $display("[TB] FAIL x0_read_en got=%0b want=00", {rf_r0_v, rf_r1_v}); end
        step();
        checks++; if (ex_v !== 1'b1 || ex_rs1_data !== 32'd0 || ex_rs2_data !== 32'd0) begin failures++; $display("[TB] FAIL x0_operands got=v%0h %0h/%0h want=v1 0/0", ex_v, ex_rs1_data, ex_rs2_data); end
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        step();
    endtask

    task automatic test_collision();
        preload(7, 32'h5555);
        preload(3, 32'h3333);
        drive(1, 7, 3, 32'h0000_0C01, 1, 7, 32'hABCD, 1);
        checks++; if (rf_w_v !== 1'b1) begin failures++; $display("[TB] FAIL coll_write_en got=%0h want=1", rf_w_v); end
        checks++; if (rf_r0_v !== 1'b0) begin failures++; $display("[TB] FAIL coll_read0_en got=%0h want=0", rf_r0_v); end
`ifdef RF_READ_BYPASS_EN
        checks++; if (id_ready !== 1'b1) begin failures++; $display("[TB] FAIL coll_id_ready got=%0h want=1", id_ready); end
        step();
`else
        checks++; if (id_ready !== 1'b0) begin failures++; $display("[TB] FAIL coll_id_ready got=%0h want=0", id_ready); end
        step();
        checks++; if (ex_v !== 1'b0) begin failures++; $display("[TB] FAIL coll_bubble got=%0h want=0", ex_v); end
        drive(1, 7, 3, 32'h0000_0C01, 0, 0, 0, 1);
        checks++; if (id_ready !== 1'b1 || rf_r0_v !== 1'b1) begin failures++; $display("[TB] FAIL coll_retry got=rdy%0h r0v%0h want=rdy1 r0v1", id_ready, rf_r0_v); end
        step();
`endif
        checks++; if (ex_v !== 1'b1 || ex_rs1_data !== 32'hABCD || ex_rs2_data !== 32'h3333) begin failures++; $display("[TB] FAIL coll_operands got=v%0h %0h/%0h want=v1 abcd/3333", ex_v, ex_rs1_data, ex_rs2_data); end
        checks++; if (ex_tag !== 32'h0000_0C01) begin failures++; $display("[TB] FAIL coll_tag got=%0h want=c01", ex_tag); end
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        step();
    endtask

    task automatic test_stall_snoop();
        logic [31:0] want [4];
        want = '{32'h1, 32'h1, 32'h2, 32'h2};
        preload(9, 32'h1);
        preload(4, 32'h4444);
        drive(1, 4, 9, 32'h0000_5701, 0, 0, 0, 0);
        checks++; if (id_ready !== 1'b1) begin failures++; $display("[TB] FAIL stall_accept_ready got=%0h want=1", id_ready); end
        step();
        for (int c = 0; c < 4; c++) begin
            checks++; if (ex_v !== 1'b1 || ex_rs2_data !== want[c]) begin failures++; $display("[TB] FAIL stall_rs2_c%0d got=v%0h %0h want=v1 %0h", c, ex_v, ex_rs2_data, want[c]); end
            checks++; if (ex_rs1_data !== 32'h4444) begin failures++; $display("[TB] FAIL stall_rs1_c%0d got=%0h want=4444", c, ex_rs1_data); end
            drive(0, 0, 0, 0, (c == 1) ? 1 : 0, 9, 32'h2, (c == 3) ? 1 : 0);
            checks++; if (id_ready !== (c == 3)) begin failures++; $display("[TB] FAIL stall_id_ready_c%0d got=%0h want=%0h", c, id_ready, (c == 3)); end
            step();
        end
        checks++; if (ex_v !== 1'b0) begin failures++; $display("[TB] FAIL stall_drain got=%0h want=0", ex_v); end
    endtask

    task automatic test_back_to_back();
        int r1, r2, wv, rd, wd;
        int tg;
        for (int i = 0; i < 4; i++) begin
            r1 = $urandom_range(0, 31); r2 = $urandom_range(0, 31); tg = $urandom;
            wv = $urandom_range(0, 1); rd = $urandom_range(0, 31); wd = $urandom;
            if (rd == r1 || rd == r2) wv = 0;
            drive(1, r1, r2, tg, wv, rd, wd, 1);
            checks++; if (id_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ready_%0d got=%0h want=1", i, id_ready); end
            step();
            checks++; if (ex_v !== 1'b1 || ex_tag !== 32'(tg)) begin failures++; $display("[TB] FAIL b2b_valid_tag_%0d got=v%0h %0h want=v1 %0h", i, ex_v, ex_tag, tg); end
            checks++; if (ex_rs1_data !== model_opnd(r1) || ex_rs2_data !== model_opnd(r2)) begin failures++; $display("[TB] FAIL b2b_operands_%0d got=%0h/%0h want=%0h/%0h", i, ex_rs1_data, ex_rs2_data, model_opnd(r1), model_opnd(r2)); end
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        step();
        checks++; if (ex_v !== 1'b0) begin failures++; $display("[TB] FAIL b2b_drain got=%0h want=0", ex_v); end
    endtask

    task automatic test_reset_in_held();
        preload(12, 32'hC0C0);
        drive(1, 12, 0, 32'h0000_0E01, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        checks++; if (ex_v !== 1'b1) begin failures++; $display("[TB] FAIL held_before_reset got=%0h want=1", ex_v); end
        #2;
        reset = 1'b1;
        #1;
        exp_valid = 1'b0;
        checks++; if (ex_v !== 1'b0 || id_ready !== 1'b1) begin failures++; $display("[TB] FAIL async_reset got=v%0h rdy%0h want=v0 rdy1", ex_v, id_ready); end
        @(negedge clk);
        reset = 1'b0;
        drive(1, 12, 5, 32'h0000_0E02, 0, 0, 0, 1);
        checks++; if (id_ready !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_ready got=%0h want=1", id_ready); end
        step();
        checks++; if (ex_v !== 1'b1 || ex_rs1_data !== 32'hC0C0 || ex_rs2_data !== model_opnd(5) || ex_tag !== 32'h0000_0E02) begin failures++; $display("[TB] FAIL post_reset_accept got=v%0h %0h/%0h tag%0h want=v1 c0c0/%0h tag e02", ex_v, ex_rs1_data, ex_rs2_data, ex_tag, model_opnd(5)); end
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        step();
    endtask

    task automatic test_random();
        logic exp_rdy, exp_acc, exp_wv;
        int r1, r2, rd;
        for (int c = 0; c < 400; c++) begin
            r1 = $urandom_range(0, 7);
            r2 = $urandom_range(0, 7);
            rd = $urandom_range(0, 7);
            drive(($urandom_range(0, 9) < 7) ? 1 : 0, r1, r2, $urandom, $urandom_range(0, 1), rd, $urandom,
                  ($urandom_range(0, 9) < 6) ? 1 : 0);
            exp_rdy = model_ready();
            exp_acc = id_v && exp_rdy;
            exp_wv  = model_wv();
            checks++; if (id_ready !== exp_rdy) begin failures++; $display("[TB] FAIL rnd_id_ready c%0d got=%0h want=%0h", c, id_ready, exp_rdy); end
            checks++; if (rf_w_v !== exp_wv) begin failures++; $display("[TB] FAIL rnd_w_v c%0d got=%0h want=%0h", c, rf_w_v, exp_wv); end
            checks++; if (rf_r0_v !== (exp_acc && r1 != 0 && !(exp_wv && rd == r1))) begin failures++; $display("[TB] FAIL rnd_r0_v c%0d got=%0h", c, rf_r0_v); end
            checks++; if (rf_r1_v !== (exp_acc && r2 != 0 && !(exp_wv && rd == r2))) begin failures++; $display("[TB] FAIL rnd_r1_v c%0d got=%0h", c, rf_r1_v); end
            step();
            checks++; if (ex_v !== exp_valid) begin failures++; $display("[TB] FAIL rnd_ex_v c%0d got=%0h want=%0h", c, ex_v, exp_valid); end
            if (exp_valid) begin
                checks++; if (ex_rs1_data !== model_opnd(exp_rs1)) begin failures++; $display("[TB] FAIL rnd_rs1 c%0d got=%0h want=%0h", c, ex_rs1_data, model_opnd(exp_rs1)); end
                checks++; if (ex_rs2_data !== model_opnd(exp_rs2)) begin failures++; $display("[TB] FAIL rnd_rs2 c%0d got=%0h want=%0h", c, ex_rs2_data, model_opnd(exp_rs2)); end
                checks++; if (ex_tag !== exp_tag) begin failures++; $display("[TB] FAIL rnd_tag c%0d got=%0h want=%0h", c, ex_tag, exp_tag); end
            end
        end
    endtask

    initial begin
        logic [31:0] d;
        for (int i = 0; i < 32; i++) begin
            d = $urandom;
            mem[i]  = d;
            arch[i] = d;
        end
        exp_rs1 = 0; exp_rs2 = 0; exp_tag = 0;
        test_reset();
        test_basic_read();
        test_zero_reg();
        test_collision();
        test_stall_snoop();
        test_back_to_back();
        test_reset_in_held();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
